noc_output_allocator: RTL and testbench
=======================================

Name: noc_output_allocator

Overview:
- Per-output-port switch allocator for the NoC router.
- Arbitrates among NUM_INPUTS input-port requesters targeting one output port, with round-robin fairness.
- Holds a wormhole lock from head flit to tail flit so packets never interleave.
- Tracks downstream buffer credits, gates each flit transfer on credit availability, and drives the registered crossbar select and send strobe for the output link.

Parameters:
- NUM_INPUTS, 5, number of requesting input ports; index 0 is the local injection port.
- FLIT_BUFFER_DEPTH, 4, downstream input-buffer depth; initial and maximum credit count.
- CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width.
- SEL_WIDTH, $clog2(NUM_INPUTS), width of the encoded select.

Ports:
- clk_noc  in  1  NoC clock, single clock domain.
- rst_noc  in  1  Asynchronous, active-high reset.
- req  in  NUM_INPUTS  Input i has a flit at its buffer head routed to this output.
- req_is_tail  in  NUM_INPUTS  The head flit of input i is a tail flit. Single-flit packets have head = tail.
- disable_in  in  NUM_INPUTS  Turn-disable mask from DISABLE_TURNS. A set bit blocks new packets from input i.
- credit_in  in  1  One credit returned by the downstream buffer.
- grant  out  NUM_INPUTS  One-hot, combinational. The flit of input i is dequeued this cycle.
- sel_out  out  SEL_WIDTH  Registered crossbar select for the flit sent next cycle.
- send_out  out  1  Registered strobe: a flit is on the output link this cycle.
- is_tail_out  out  1  Registered tail flag accompanying send_out.
- locked  out  1  A packet is in progress (state LOCKED).
- credits  out  CREDIT_WIDTH  Current credit count.
- credit_err  out  1  Sticky flag: credit_in received while credits == FLIT_BUFFER_DEPTH.

Behaviour:
- Reset values:
  - state = IDLE.
  - credits = FLIT_BUFFER_DEPTH.
  - rr_ptr = 0.
  - sel_out = 0, send_out = 0, is_tail_out = 0, locked = 0, credit_err = 0.
  - grant = 0 while rst_noc is asserted.
- Fire condition: fire = |grant. grant is nonzero only if credits > 0. At most one bit of grant is set.
- IDLE:
  - Eligible set = req & ~disable_in.
  - Grant goes to the first eligible index at or after rst_ptr, searching cyclically (rr_ptr, rr_ptr+1, …, wrapping at NUM_INPUTS-1 → 0).
  - On fire with req_is_tail = 0: go to LOCKED and latch owner = granted index.
  - On fire with req_is_tail = 1 (single-flit packet): stay in IDLE and set rr_ptr = granted+1 mod NUM_INPUTS.
- LOCKED:
  - grant[owner] = req[owner] && credits > 0. All other grant bits are 0.
  - disable_in is ignored, so a packet in flight always completes.
  - On fire with req_is_tail[owner] = 1: go to IDLE and set rr_ptr = owner+1 mod NUM_INPUTS.
  - Bubbles (req[owner] = 0) keep the lock and produce no grant.
- rr_ptr changes only on packet completion, never on head-flit grants.
- Output register, 1-cycle latency: on the cycle after fire, send_out = 1, sel_out = encoded grant, is_tail_out = tail of the fired flit. Otherwise send_out = 0, and sel_out / is_tail_out hold their previous values.
- Credit update per cycle:
  - fire && !credit_in → credits - 1.
  - !fire && credit_in → credits + 1, saturating at FLIT_BUFFER_DEPTH; set credit_err if already at FLIT_BUFFER_DEPTH.
  - fire && credit_in → unchanged.
  - A credit arriving while credits == 0 may not be used for a grant in the same cycle. Grant qualification uses the registered count only.
- Back-to-back: a new packet may be granted in the cycle immediately after a tail fires, so there are no dead cycles between packets.
- Reset mid-packet: the lock, credits and pointer are discarded. Upstream and downstream buffers are reset by the same reset.
- credit_err is cleared only by reset.

Decomposition:
- Package noc_alloc_pkg:
  - alloc_state_e enum {IDLE, LOCKED}.
  - onehot_to_bin function.
- Sub-module rr_arbiter (NUM_INPUTS), purely combinational:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, any-grant flag.
  - Implemented as a double-width masked priority encoder.
- The allocator contains the FSM, credit counter, pointer update and output registers.

Test Plan:
- Reset, then req = 5'b00110, tails = 1, credit_in = 0 → grants alternate 1,2,1,2. send_out follows each grant by 1 cycle with sel_out = 1,2,1,2. credits drops 4→0 after 4 flits, then grant = 0.
- Input 3 sends a 3-flit packet (tail on flit 3) while input 0 requests continuously, credit_in = 1 every cycle → grants 3,3,3 with locked = 1, then input 0 in the next cycle. Pointer becomes 4, credits stay 4.
- credits = 0 with req[2] = 1; pulse credit_in → no grant in the pulse cycle, grant[2] in the following cycle, credits 0→1→0.
- Set disable_in[1] = 1 while input 1 is mid-packet → lock holds and the packet completes. A new head from input 1 in IDLE is never granted while input 4 is granted.
- credit_in = 1 at credits = 4 with no req → credits stays 4, credit_err = 1 sticky, cleared only by rst_noc.
- Assert rst_noc asynchronously in LOCKED with credits = 1 → same cycle: grant = 0, send_out = 0, locked = 0. After release: credits = 4, the first grant goes to the lowest-index requester.

Source files
------------

// File: rtl/noc_alloc_pkg.sv
// +--------------------------------------------------------------------+
// | noc_alloc_pkg                                                      |
// | Shared types and helpers for the NoC output-port allocator.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package noc_alloc_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

  localparam int unsigned ONEHOT_MAX = 32;

  // OR-reduction of set-bit indices; exact for one-hot or all-zero inputs.
  function automatic logic [4:0] onehot_to_bin(input logic [ONEHOT_MAX-1:0] oh);
    logic [4:0] b;
    b = '0;
    for (int i = 0; i < ONEHOT_MAX; i++) begin
      if (oh[i]) b = b | 5'(i);
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +--------------------------------------------------------------------+
// | rr_arbiter                                                         |
// | Combinational round-robin arbiter, double-width priority encoder.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int NUM_INPUTS = 5,
  parameter int PTR_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req_i,
  input  logic [PTR_WIDTH-1:0]  ptr_i,
  output logic [NUM_INPUTS-1:0] gnt_o,
  output logic                  any_o
);

  logic [NUM_INPUTS-1:0]   mask;
  logic [2*NUM_INPUTS-1:0] dreq;
  logic [2*NUM_INPUTS-1:0] dgnt;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      mask[i] = (PTR_WIDTH'(i) >= ptr_i);
    end
  end

  // Lower half holds requests at/after the pointer; upper half catches the wrap.
  assign dreq  = {req_i, req_i & mask};
  assign dgnt  = dreq & (~dreq + (2*NUM_INPUTS)'(1));
  assign gnt_o = dgnt[NUM_INPUTS-1:0] | dgnt[2*NUM_INPUTS-1:NUM_INPUTS];
  assign any_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/noc_output_allocator.sv
// +--------------------------------------------------------------------+
// | noc_output_allocator                                               |
// | Per-output switch allocator: RR arbitration, wormhole lock,        |
// | credit flow control and registered crossbar select / send strobe.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module noc_output_allocator
  import noc_alloc_pkg::*;
#(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH+1),
  parameter int SEL_WIDTH         = $clog2(NUM_INPUTS)
) (
  input  logic                    clk_noc,
  input  logic                    rst_noc,
  input  logic [NUM_INPUTS-1:0]   req,
  input  logic [NUM_INPUTS-1:0]   req_is_tail,
  input  logic [NUM_INPUTS-1:0]   disable_in,
  input  logic                    credit_in,
  output logic [NUM_INPUTS-1:0]   grant,
  output logic [SEL_WIDTH-1:0]    sel_out,
  output logic                    send_out,
  output logic                    is_tail_out,
  output logic                    locked,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic                    credit_err
);

  localparam logic [CREDIT_WIDTH-1:0] C_MAX_CREDITS = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [SEL_WIDTH-1:0]    C_LAST_INPUT  = SEL_WIDTH'(NUM_INPUTS-1);

  alloc_state_e            state_q, state_d;
  logic [SEL_WIDTH-1:0]    owner_q, owner_d;
  logic [SEL_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
  logic                    credit_err_q, credit_err_d;
  logic [SEL_WIDTH-1:0]    sel_q;
  logic                    send_q, tail_q;

  logic [NUM_INPUTS-1:0]   arb_req, arb_gnt;
  logic                    arb_any;
  logic                    credit_ok;
  logic                    fire, fire_tail;
  logic [SEL_WIDTH-1:0]    fire_idx;

  function automatic logic [SEL_WIDTH-1:0] ptr_inc(input logic [SEL_WIDTH-1:0] idx);
    return (idx == C_LAST_INPUT) ? '0 : idx + 1'b1;
  endfunction

  assign arb_req   = req & ~disable_in;
  // Only the registered count qualifies a grant; same-cycle returns wait a cycle.
  assign credit_ok = (credits_q != '0);

  rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS),
    .PTR_WIDTH  (SEL_WIDTH)
  ) u_rr_arbiter (
    .req_i (arb_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .any_o (arb_any)
  );

  always_comb begin
    grant    = '0;
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;

    unique case (state_q)
      IDLE:    if (arb_any && credit_ok) grant = arb_gnt;
      LOCKED:  if (req[owner_q] && credit_ok) grant[owner_q] = 1'b1;
      default: grant = '0;
    endcase
    if (rst_noc) grant = '0;

    fire      = |grant;
    fire_idx  = SEL_WIDTH'(onehot_to_bin(ONEHOT_MAX'(grant)));
    fire_tail = |(grant & req_is_tail);

    if (fire) begin
      unique case (state_q)
        IDLE: begin
          if (fire_tail) begin
            rr_ptr_d = ptr_inc(fire_idx);
          end else begin
            state_d = LOCKED;
            owner_d = fire_idx;
          end
        end
        LOCKED: begin
          if (fire_tail) begin
            state_d  = IDLE;
            rr_ptr_d = ptr_inc(owner_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    if (fire && !credit_in) begin
      credits_d = credits_q - 1'b1;
    end else if (!fire && credit_in) begin
      if (credits_q == C_MAX_CREDITS) credit_err_d = 1'b1;
      else                            credits_d    = credits_q + 1'b1;
    end
  end

  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      credits_q    <= C_MAX_CREDITS;
      credit_err_q <= 1'b0;
      sel_q        <= '0;
      send_q       <= 1'b0;
      tail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
      send_q       <= fire;
      if (fire) begin
        sel_q  <= fire_idx;
        tail_q <= fire_tail;
      end
    end
  end

  assign sel_out     = sel_q;
  assign send_out    = send_q;
  assign is_tail_out = tail_q;
  assign locked      = (state_q == LOCKED);
  assign credits     = credits_q;
  assign credit_err  = credit_err_q;

endmodule

`default_nettype wire

// File: tb/tb_noc_output_allocator.sv
// +--------------------------------------------------------------------+
// | tb_noc_output_allocator                                            |
// | Directed scoreboard bench for the NoC output allocator.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_noc_output_allocator;

  logic       clk_noc;
  logic       rst_noc;
  logic [4:0] req;
  logic [4:0] req_is_tail;
  logic [4:0] disable_in;
  logic       credit_in;
  logic [4:0] grant;
  logic [2:0] sel_out;
  logic       send_out;
  logic       is_tail_out;
  logic       locked;
  logic [2:0] credits;
  logic       credit_err;

  int n_vec  = 0;
  int n_fail = 0;

  // Expected link transfers: {tail, sel}
  logic [3:0] sb[$];

  noc_output_allocator #(
    .NUM_INPUTS        (5),
    .FLIT_BUFFER_DEPTH (4)
  ) dut (
    .clk_noc     (clk_noc),
    .rst_noc     (rst_noc),
    .req         (req),
    .req_is_tail (req_is_tail),
    .disable_in  (disable_in),
    .credit_in   (credit_in),
    .grant       (grant),
    .sel_out     (sel_out),
    .send_out    (send_out),
    .is_tail_out (is_tail_out),
    .locked      (locked),
    .credits     (credits),
    .credit_err  (credit_err)
  );

  initial begin
    clk_noc = 1'b0;
    forever #5 clk_noc = ~clk_noc;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] idx_of(input logic [4:0] oh);
    logic [2:0] b;
    b = '0;
    for (int i = 0; i < 5; i++) if (oh[i]) b = 3'(i);
    return b;
  endfunction

  // Monitor: every send on the link must match the oldest expected transfer.
  always @(negedge clk_noc) begin
    if (!rst_noc && send_out) begin
      if (sb.size() == 0) begin
        chk("unexpected_send", 32'(sel_out), 32'hFF);
      end else begin
        logic [3:0] e;
        e = sb.pop_front();
        chk("send_sel", 32'(sel_out), 32'(e[2:0]));
        chk("send_tail", 32'(is_tail_out), 32'(e[3]));
      end
    end
  end

  // Starts at posedge+1: drive, check combinational grant, advance to next posedge+1.
  task automatic step(input logic [4:0] r, input logic [4:0] t, input logic [4:0] d,
                      input logic c, input logic [4:0] exp_g, input string name);
    req = r; req_is_tail = t; disable_in = d; credit_in = c;
    #1;
    chk(name, 32'(grant), 32'(exp_g));
    if (exp_g != 5'b0) sb.push_back({|(exp_g & t), idx_of(exp_g)});
    @(posedge clk_noc);
    #1;
  endtask

  initial begin
    rst_noc = 1'b1;
    req = 5'b00110; req_is_tail = 5'b11111; disable_in = '0; credit_in = 1'b0;
    #3;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_credits", 32'(credits), 32'd4);
    chk("rst_send", 32'(send_out), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(credit_err), 32'd0);
    chk("rst_sel", 32'(sel_out), 32'd0);
    @(posedge clk_noc); #1;
    rst_noc = 1'b0;

    // Single-flit packets from inputs 1 and 2 alternate until credits run out
    step(5'b00110, 5'b11111, 5'b0, 1'b0, 5'b00010, "s1_g1");
    step(5'b00110, 5'b11111, 5'b0, 1'b0, 5'b00100, "s1_g2");
    step(5'b00110, 5'b11111, 5'b0, 1'b0, 5'b00010, "s1_g3");
    step(5'b00110, 5'b11111, 5'b0, 1'b0, 5'b00100, "s1_g4");
    step(5'b00110, 5'b11111, 5'b0, 1'b0, 5'b00000, "s1_nocredit");
    chk("s1_credits0", 32'(credits), 32'd0);

    for (int i = 0; i < 4; i++) step(5'b0, 5'b0, 5'b0, 1'b1, 5'b0, "restore_a");
    chk("s2_credits4", 32'(credits), 32'd4);

    // 3-flit wormhole from input 3 while input 0 waits
    step(5'b01001, 5'b00000, 5'b0, 1'b1, 5'b01000, "s2_head");
    chk("s2_locked_h", 32'(locked), 32'd1);
    step(5'b01001, 5'b00000, 5'b0, 1'b1, 5'b01000, "s2_body");
    chk("s2_locked_b", 32'(locked), 32'd1);
    step(5'b01001, 5'b01000, 5'b0, 1'b1, 5'b01000, "s2_tail");
    chk("s2_unlocked", 32'(locked), 32'd0);
    step(5'b00001, 5'b00001, 5'b0, 1'b1, 5'b00001, "s2_next");
    chk("s2_credits", 32'(credits), 32'd4);

    // Credit starvation and single-cycle return latency
    for (int i = 0; i < 4; i++) step(5'b00100, 5'b00100, 5'b0, 1'b0, 5'b00100, "s3_drain");
    step(5'b00100, 5'b00100, 5'b0, 1'b0, 5'b00000, "s3_zero");
    chk("s3_credits0", 32'(credits), 32'd0);
    step(5'b00100, 5'b00100, 5'b0, 1'b1, 5'b00000, "s3_pulse");
    chk("s3_credits1", 32'(credits), 32'd1);
    step(5'b00100, 5'b00100, 5'b0, 1'b0, 5'b00100, "s3_use");
    chk("s3_credits_back0", 32'(credits), 32'd0);

    for (int i = 0; i < 4; i++) step(5'b0, 5'b0, 5'b0, 1'b1, 5'b0, "restore_b");
    chk("s4_credits4", 32'(credits), 32'd4);

    // Disable lands mid-packet; new heads from input 1 are blocked
    step(5'b00010, 5'b00000, 5'b00000, 1'b1, 5'b00010, "s4_head");
    step(5'b00010, 5'b00000, 5'b00010, 1'b1, 5'b00010, "s4_body_dis");
    chk("s4_locked", 32'(locked), 32'd1);
    step(5'b00010, 5'b00010, 5'b00010, 1'b1, 5'b00010, "s4_tail_dis");
    chk("s4_unlocked", 32'(locked), 32'd0);
    step(5'b10010, 5'b10010, 5'b00010, 1'b1, 5'b10000, "s4_dis_a");
    step(5'b10010, 5'b10010, 5'b00010, 1'b1, 5'b10000, "s4_dis_b");
    step(5'b10010, 5'b10010, 5'b00000, 1'b1, 5'b00010, "s4_ptr_wrap");
    chk("s4_credits", 32'(credits), 32'd4);
    chk("s4_err", 32'(credit_err), 32'd0);

    // Credit overflow is sticky
    step(5'b0, 5'b0, 5'b0, 1'b1, 5'b0, "s5_over");
    chk("s5_credits", 32'(credits), 32'd4);
    chk("s5_err", 32'(credit_err), 32'd1);
    step(5'b0, 5'b0, 5'b0, 1'b0, 5'b0, "s5_idle");
    chk("s5_err_sticky", 32'(credit_err), 32'd1);

    // Asynchronous reset in the middle of a packet
    step(5'b00100, 5'b0, 5'b0, 1'b0, 5'b00100, "s6_head");
    step(5'b00100, 5'b0, 5'b0, 1'b0, 5'b00100, "s6_body1");
    step(5'b00100, 5'b0, 5'b0, 1'b0, 5'b00100, "s6_body2");
    chk("s6_credits1", 32'(credits), 32'd1);
    chk("s6_locked", 32'(locked), 32'd1);
    chk("s6_send", 32'(send_out), 32'd1);
    req = 5'b00100; req_is_tail = 5'b0;
    #1;
    chk("s6_grant_pre", 32'(grant), 32'h04);
    #1;
    rst_noc = 1'b1;
    #1;
    chk("s6_rst_grant", 32'(grant), 32'h0);
    chk("s6_rst_send", 32'(send_out), 32'd0);
    chk("s6_rst_locked", 32'(locked), 32'd0);
    chk("s6_rst_credits", 32'(credits), 32'd4);
    chk("s6_rst_err", 32'(credit_err), 32'd0);
    sb.delete();
    @(posedge clk_noc); #1;
    rst_noc = 1'b0;
    step(5'b10100, 5'b10100, 5'b0, 1'b0, 5'b00100, "s6_after");
    step(5'b0, 5'b0, 5'b0, 1'b0, 5'b0, "drain1");
    step(5'b0, 5'b0, 5'b0, 1'b0, 5'b0, "drain2");
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
